// File: rtl/rx_link_if.sv
// Bundle of PHY-chain status inputs and per-stage reset/mode outputs for rx_link_ctrl.
// master = controller side, slave = PHY/stimulus side; relock_cnt exists only with RELOCK_CNT_EN.
`timescale 1ns/1ps
interface rx_link_if;
  logic       pll_lock;
  logic       comma_det;
  logic       dec_err;
  logic [1:0] cfg_width;
  logic       reset_pll;
  logic       reset_sp;
  logic       reset_conv;
  logic [1:0] pclk;
  logic       rx_ready;
  logic [2:0] link_state;
  logic [3:0] err_cnt;
`ifdef RELOCK_CNT_EN
  logic [7:0] relock_cnt;
`endif

  modport master (
    input  pll_lock, comma_det, dec_err, cfg_width,
    output reset_pll, reset_sp, reset_conv, pclk, rx_ready, link_state, err_cnt
`ifdef RELOCK_CNT_EN
    , output relock_cnt
`endif
  );

  modport slave (
    output pll_lock, comma_det, dec_err, cfg_width,
    input  reset_pll, reset_sp, reset_conv, pclk, rx_ready, link_state, err_cnt
`ifdef RELOCK_CNT_EN
    , input relock_cnt
`endif
  );
endinterface

// File: rtl/rx_link_ctrl.sv
// RX PHY bring-up/supervision FSM; all outputs registered (state change visible the cycle after the cause).
// No backpressure: pulse inputs are sampled every cycle. RELOCK_CNT_EN adds a saturating relock counter.
`timescale 1ns/1ps
module rx_link_ctrl #(
  parameter int PLL_RST_CYC   = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int COMMA_NEED    = 4,
  parameter int ALIGN_TIMEOUT = 2048,
  parameter int ERR_THRESH    = 8,
  parameter int ERR_WINDOW    = 256
) (
  input  logic      clk,
  input  logic      reset,
  rx_link_if.master lnk
);
  localparam int DP_RST_CYC = 4;
  localparam int TMR_MAX = (ALIGN_TIMEOUT > LOCK_TIMEOUT)
                         ? ((ALIGN_TIMEOUT > ERR_WINDOW) ? ALIGN_TIMEOUT : ERR_WINDOW)
                         : ((LOCK_TIMEOUT > ERR_WINDOW) ? LOCK_TIMEOUT : ERR_WINDOW);
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int CW = $clog2(COMMA_NEED + 1);

  localparam logic [TW-1:0] PLL_LAST   = TW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] DP_LAST    = TW'(DP_RST_CYC - 1);
  localparam logic [TW-1:0] ALIGN_LAST = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [TW-1:0] WIN_LAST   = TW'(ERR_WINDOW - 1);
  localparam logic [CW-1:0] COMMA_LIM  = CW'(COMMA_NEED);
  localparam logic [3:0]    ERR_LIM    = 4'(ERR_THRESH);

  typedef enum logic [2:0] {
    S_RST_PLL   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RST_DP    = 3'd2,
    S_ALIGN     = 3'd3,
    S_LOCKED    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [CW-1:0] comma_cnt, comma_nxt;
  logic [3:0]    err_cnt, err_nxt;
  logic          reset_pll_q, reset_sp_q, reset_conv_q, rx_ready_q;
  logic          reset_pll_nxt, reset_sp_nxt, reset_conv_nxt, rx_ready_nxt;
  logic [1:0]    pclk_q;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr + TW'(1);
    comma_nxt = comma_cnt;
    err_nxt   = err_cnt;
    case (state)
      S_RST_PLL:   if (tmr == PLL_LAST) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lnk.pll_lock)           state_nxt = S_RST_DP;
        else if (tmr == LOCK_LAST)  state_nxt = S_RST_PLL;
      end
      S_RST_DP:    if (tmr == DP_LAST) state_nxt = S_ALIGN;
      S_ALIGN: begin
        // an error in the same cycle as a comma discards the run
        if (lnk.dec_err)        comma_nxt = '0;
        else if (lnk.comma_det) comma_nxt = comma_cnt + CW'(1);
        if (comma_nxt == COMMA_LIM) state_nxt = S_LOCKED;
        else if (tmr == ALIGN_LAST) state_nxt = S_RST_DP;
      end
      S_LOCKED: begin
        if (tmr == WIN_LAST) begin
          tmr_nxt = '0;
          err_nxt = lnk.dec_err ? 4'd1 : 4'd0;
        end else if (lnk.dec_err && err_cnt != 4'hf) begin
          err_nxt = err_cnt + 4'd1;
        end
        if (err_nxt >= ERR_LIM) state_nxt = S_RST_DP;
      end
      default: state_nxt = S_RST_PLL;
    endcase

    if ((state inside {S_RST_DP, S_ALIGN, S_LOCKED}) && !lnk.pll_lock)
      state_nxt = S_RST_PLL;

    if (state_nxt != state) begin
      tmr_nxt   = '0;
      comma_nxt = '0;
      err_nxt   = '0;
    end

    reset_pll_nxt  = (state_nxt == S_RST_PLL);
    reset_sp_nxt   = (state_nxt inside {S_RST_PLL, S_WAIT_LOCK, S_RST_DP});
    reset_conv_nxt = (state_nxt != S_LOCKED);
    rx_ready_nxt   = (state_nxt == S_LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RST_PLL;
      tmr          <= '0;
      comma_cnt    <= '0;
      err_cnt      <= '0;
      reset_pll_q  <= 1'b1;
      reset_sp_q   <= 1'b1;
      reset_conv_q <= 1'b1;
      rx_ready_q   <= 1'b0;
      pclk_q       <= 2'b00;
    end else begin
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      comma_cnt    <= comma_nxt;
      err_cnt      <= err_nxt;
      reset_pll_q  <= reset_pll_nxt;
      reset_sp_q   <= reset_sp_nxt;
      reset_conv_q <= reset_conv_nxt;
      rx_ready_q   <= rx_ready_nxt;
      // sampled once per datapath reset, while the converter is certainly held
      if (state == S_RST_DP && tmr == '0) pclk_q <= lnk.cfg_width;
    end
  end

`ifdef RELOCK_CNT_EN
  logic [7:0] relock_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      relock_q <= 8'd0;
    else if (state == S_LOCKED && state_nxt != S_LOCKED && relock_q != 8'hff)
      relock_q <= relock_q + 8'd1;
  end
  assign lnk.relock_cnt = relock_q;
`endif

  assign lnk.reset_pll  = reset_pll_q;
  assign lnk.reset_sp   = reset_sp_q;
  assign lnk.reset_conv = reset_conv_q;
  assign lnk.pclk       = pclk_q;
  assign lnk.rx_ready   = rx_ready_q;
  assign lnk.link_state = state;
  assign lnk.err_cnt    = err_cnt;
endmodule

// File: tb/tb_rx_link_ctrl.sv
// Scoreboard bench for rx_link_ctrl: expected state transitions (state, cycle) are queued as stimulus is
// driven and popped by a monitor whenever LINK_STATE changes; point checks cover counters and PCLK.
`timescale 1ns/1ps
module tb_rx_link_ctrl;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0, n_chk = 0, n_fail = 0, exp_relock = 0;

  rx_link_if lnk();
  rx_link_ctrl dut (.clk(clk), .reset(reset), .lnk(lnk));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    int         cyc;
  } exp_t;
  exp_t       sb[$];
  logic       mon_en = 1'b0;
  logic [2:0] prev_st = 3'd0;
  logic [1:0] prev_pclk = 2'd0;

  // {reset_pll, reset_sp, reset_conv, rx_ready} required in each state
  function automatic logic [3:0] exp_outs(input logic [2:0] st);
    case (st)
      3'd0:    return 4'b1110;
      3'd1:    return 4'b0110;
      3'd2:    return 4'b0110;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && lnk.link_state != prev_st) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_trans", 32'(lnk.link_state), 32'(prev_st));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("trans_state", 32'(lnk.link_state), 32'(e.st));
        check_eq("trans_cycle", cyc, e.cyc);
        check_eq("trans_outs", 32'({lnk.reset_pll, lnk.reset_sp, lnk.reset_conv, lnk.rx_ready}),
                 32'(exp_outs(e.st)));
      end
    end
    if (mon_en && lnk.pclk != prev_pclk)
      check_eq("pclk_chg_conv", 32'(lnk.reset_conv), 32'd1);
    prev_st   = lnk.link_state;
    prev_pclk = lnk.pclk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input logic [2:0] st, input int c);
    exp_t e;
    e.st  = st;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    check_eq("sb_left", sb.size(), 0);
    sb.delete();
    lnk.comma_det = 1'b0;
    lnk.dec_err   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_pll",   32'(lnk.reset_pll),  32'd1);
    check_eq("rst_sp",    32'(lnk.reset_sp),   32'd1);
    check_eq("rst_conv",  32'(lnk.reset_conv), 32'd1);
    check_eq("rst_pclk",  32'(lnk.pclk),       32'd0);
    check_eq("rst_ready", 32'(lnk.rx_ready),   32'd0);
    check_eq("rst_state", 32'(lnk.link_state), 32'd0);
    check_eq("rst_err",   32'(lnk.err_cnt),    32'd0);
`ifdef RELOCK_CNT_EN
    check_eq("rst_relock", 32'(lnk.relock_cnt), 32'd0);
`endif
    tick(2);
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic comma_pulse(input logic err);
    lnk.comma_det = 1'b1;
    lnk.dec_err   = err;
    tick(1);
    lnk.comma_det = 1'b0;
    lnk.dec_err   = 1'b0;
    tick(1);
  endtask

  task automatic err_pulse();
    lnk.dec_err = 1'b1;
    tick(1);
    lnk.dec_err = 1'b0;
    tick(1);
  endtask

  task automatic bring_up_to_align(input logic [1:0] w, output int t_align);
    int r;
    lnk.cfg_width = w;
    lnk.pll_lock  = 1'b0;
    do_reset();
    r = cyc;
    expect_at(3'd1, r + 8);
    while (cyc < r + 20) tick(1);
    lnk.pll_lock = 1'b1;
    expect_at(3'd2, cyc + 1);
    expect_at(3'd3, cyc + 5);
    t_align = cyc + 5;
    wait_drain(50);
    check_eq("pclk_load", 32'(lnk.pclk), 32'(w));
  endtask

  task automatic lock_up(input logic [1:0] w, output int t_lock);
    int ta;
    bring_up_to_align(w, ta);
    repeat (3) comma_pulse(1'b0);
    expect_at(3'd4, cyc + 1);
    t_lock = cyc + 1;
    comma_pulse(1'b0);
    wait_drain(10);
    check_eq("locked_ready", 32'(lnk.rx_ready), 32'd1);
  endtask

  task automatic burst_relock();
    repeat (7) err_pulse();
    check_eq("burst_err7", 32'(lnk.err_cnt), 32'd7);
    check_eq("burst_hold", 32'(lnk.link_state), 32'd4);
    expect_at(3'd2, cyc + 1);
    expect_at(3'd3, cyc + 5);
    err_pulse();
    exp_relock++;
    check_eq("burst_err_clr", 32'(lnk.err_cnt), 32'd0);
    check_eq("burst_not_rdy", 32'(lnk.rx_ready), 32'd0);
    wait_drain(20);
    repeat (3) comma_pulse(1'b0);
    expect_at(3'd4, cyc + 1);
    comma_pulse(1'b0);
    wait_drain(10);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int t, r;
    lnk.pll_lock  = 1'b0;
    lnk.comma_det = 1'b0;
    lnk.dec_err   = 1'b0;
    lnk.cfg_width = 2'b00;

    // bring-up: lock at cycle 20, four clean commas
    lock_up(2'b01, t);
    check_eq("bringup_pclk", 32'(lnk.pclk), 32'd1);

    // alignment: broken comma runs, including comma+error in one cycle
    bring_up_to_align(2'b11, t);
    repeat (2) comma_pulse(1'b0);
    err_pulse();
    repeat (3) comma_pulse(1'b0);
    tick(4);
    check_eq("align_hold3", 32'(lnk.link_state), 32'd3);
    comma_pulse(1'b1);
    repeat (3) comma_pulse(1'b0);
    check_eq("align_clr_wins", 32'(lnk.link_state), 32'd3);
    expect_at(3'd4, cyc + 1);
    comma_pulse(1'b0);
    wait_drain(10);

    // alignment timeout with no commas
    bring_up_to_align(2'b00, t);
    expect_at(3'd2, t + 2048);
    expect_at(3'd3, t + 2052);
    wait_drain(2200);
    check_eq("align_retry", 32'(lnk.link_state), 32'd3);

    // PLL lock timeout, repeating
    lnk.pll_lock = 1'b0;
    do_reset();
    r = cyc;
    expect_at(3'd1, r + 8);
    expect_at(3'd0, r + 1032);
    expect_at(3'd1, r + 1040);
    expect_at(3'd0, r + 2064);
    wait_drain(2200);
    check_eq("lock_to_rstpll", 32'(lnk.reset_pll), 32'd1);

    // error bursts force three relocks
    lock_up(2'b10, t);
    exp_relock = 0;
    repeat (3) burst_relock();
`ifdef RELOCK_CNT_EN
    check_eq("relock_cnt3", 32'(lnk.relock_cnt), 32'(exp_relock));
`endif

    // seven errors per window never unlock; wrap-cycle error counts into new window
    lock_up(2'b01, t);
    repeat (7) err_pulse();
    check_eq("win1_err7", 32'(lnk.err_cnt), 32'd7);
    while (cyc < t + 255) tick(1);
    check_eq("pre_wrap", 32'(lnk.err_cnt), 32'd7);
    lnk.dec_err = 1'b1;
    tick(1);
    lnk.dec_err = 1'b0;
    check_eq("wrap_err", 32'(lnk.err_cnt), 32'd1);
    repeat (6) err_pulse();
    check_eq("win2_err7", 32'(lnk.err_cnt), 32'd7);
    while (cyc < t + 512) tick(1);
    check_eq("wrap_clr", 32'(lnk.err_cnt), 32'd0);
    check_eq("win_locked", 32'(lnk.link_state), 32'd4);

    // width change while locked is held until PLL loss forces a new datapath reset
    lnk.cfg_width = 2'b10;
    tick(3);
    check_eq("pclk_hold", 32'(lnk.pclk), 32'd1);
    expect_at(3'd0, cyc + 1);
    lnk.pll_lock = 1'b0;
    tick(1);
    lnk.pll_lock = 1'b1;
    expect_at(3'd1, cyc + 8);
    expect_at(3'd2, cyc + 9);
    expect_at(3'd3, cyc + 13);
    wait_drain(40);
    check_eq("pclk_new", 32'(lnk.pclk), 32'd2);
`ifdef RELOCK_CNT_EN
    check_eq("relock_pll", 32'(lnk.relock_cnt), 32'd1);
`endif

    // relock, then reset mid-operation
    repeat (3) comma_pulse(1'b0);
    expect_at(3'd4, cyc + 1);
    comma_pulse(1'b0);
    wait_drain(10);
    do_reset();
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
